// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer.
//   mode_t      : operating mode, also driven out on the mode port
//   Q_*         : LED patterns loaded on entry to a mode
//   ms_to_ticks : converts a duration in ms to clock ticks, never less than 1
//   ticks_width : counter width able to hold 0..ticks-1, never less than 1
package led_seq_pkg;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_CHASE = 2'd1,
      M_BLINK = 2'd2,
      M_HOLD  = 2'd3
   } mode_t;

   localparam logic [5:0] Q_IDLE   = 6'h3F;
   localparam logic [5:0] Q_CHASE0 = 6'h3E;
   localparam logic [5:0] Q_BLINK0 = 6'h00;

   function automatic int ms_to_ticks(input int f_clk_hz, input int ms);
      int ticks;
      ticks = (f_clk_hz / 1000) * ms;
      return (ticks < 1) ? 1 : ticks;
   endfunction

   function automatic int ticks_width(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, polarity normalisation
// (pressed = 1), debounce counter and one-cycle press pulse.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   btn_raw in  raw button pin
//   press   out one-cycle pulse on an accepted not-pressed -> pressed change
module btn_debounce
   import led_seq_pkg::*;
#(
   parameter int DB_TICKS   = 1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int               CNT_W    = ticks_width(DB_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);
   localparam logic             IDLE_PIN = ACTIVE_LOW;

   logic [1:0]       sync_q, sync_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             pressed_n;

   always_comb begin
      sync_d    = {sync_q[0], btn_raw};
      pressed_n = sync_q[1] ^ ACTIVE_LOW;
      stable_d  = stable_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      if (pressed_n != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = pressed_n;
            // Only the release->press direction is reported.
            press_d  = pressed_n;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // The stable state comes out of reset as "pressed": a button held through
   // reset must be seen released before it can generate a new press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= {2{IDLE_PIN}};
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED sequencer. Three debounced buttons (A advance, B hold/
// resume, C idle) are arbitrated A > B > C and steer a mode FSM that drives the
// 6-bit LED bank as static, walking-zero chase, full blink or frozen.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   btn_a   in  raw button A (mode advance)
//   btn_b   in  raw button B (hold/resume)
//   btn_c   in  raw button C (back to idle)
//   q       out LED pattern, registered
//   mode    out current mode_t, registered
//   btn_evt out one-cycle one-hot granted press {C,B,A}
module led_mode_sequencer
   import led_seq_pkg::*;
#(
   parameter int F_CLK_HZ       = 25_000_000,
   parameter int DEBOUNCE_MS    = 20,
   parameter int STEP_MS        = 250,
   parameter int ACTIVE_LOW_BTN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_a,
   input  logic       btn_b,
   input  logic       btn_c,
   output logic [5:0] q,
   output logic [1:0] mode,
   output logic [2:0] btn_evt
);

   localparam int                DB_TICKS   = ms_to_ticks(F_CLK_HZ, DEBOUNCE_MS);
   localparam int                STEP_TICKS = ms_to_ticks(F_CLK_HZ, STEP_MS);
   localparam int                STEP_W     = ticks_width(STEP_TICKS);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_TICKS - 1);

   logic [2:0]        press;
   logic [2:0]        grant;
   logic              running;
   logic              step;
   mode_t             mode_q, mode_d;
   mode_t             saved_q, saved_d;
   logic [5:0]        q_q, q_d;
   logic [2:0]        btn_evt_q, btn_evt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

   btn_debounce #(.DB_TICKS(DB_TICKS), .ACTIVE_LOW(ACTIVE_LOW_BTN != 0)) u_db_a (
      .clk(clk), .rst(rst), .btn_raw(btn_a), .press(press[0]));
   btn_debounce #(.DB_TICKS(DB_TICKS), .ACTIVE_LOW(ACTIVE_LOW_BTN != 0)) u_db_b (
      .clk(clk), .rst(rst), .btn_raw(btn_b), .press(press[1]));
   btn_debounce #(.DB_TICKS(DB_TICKS), .ACTIVE_LOW(ACTIVE_LOW_BTN != 0)) u_db_c (
      .clk(clk), .rst(rst), .btn_raw(btn_c), .press(press[2]));

   // Fixed priority A > B > C; losing presses are simply dropped.
   always_comb begin
      grant = 3'b000;
      if (press[0])      grant = 3'b001;
      else if (press[1]) grant = 3'b010;
      else if (press[2]) grant = 3'b100;
   end

   assign running = (mode_q == M_CHASE) || (mode_q == M_BLINK);
   assign step    = running && (step_cnt_q == STEP_LAST);

   always_comb begin
      mode_d    = mode_q;
      saved_d   = saved_q;
      q_d       = q_q;
      btn_evt_d = grant;
      // Every event in CHASE/BLINK changes mode, so a step that coincides with
      // an event is naturally discarded by the if/else ordering below.
      unique case (mode_q)
         M_IDLE: begin
            if (grant[0]) begin
               mode_d = M_CHASE;
               q_d    = Q_CHASE0;
            end else if (grant[2]) begin
               q_d = Q_IDLE;
            end
         end
         M_CHASE: begin
            if (grant[0]) begin
               mode_d = M_BLINK;
               q_d    = Q_BLINK0;
            end else if (grant[1]) begin
               mode_d  = M_HOLD;
               saved_d = M_CHASE;
            end else if (grant[2]) begin
               mode_d = M_IDLE;
               q_d    = Q_IDLE;
            end else if (step) begin
               q_d = {q_q[4:0], q_q[5]};
            end
         end
         M_BLINK: begin
            if (grant[0] || grant[2]) begin
               mode_d = M_IDLE;
               q_d    = Q_IDLE;
            end else if (grant[1]) begin
               mode_d  = M_HOLD;
               saved_d = M_BLINK;
            end else if (step) begin
               q_d = ~q_q;
            end
         end
         M_HOLD: begin
            // q is left untouched so the pattern resumes where it froze.
            if (grant[1]) begin
               mode_d = saved_q;
            end else if (grant[2]) begin
               mode_d = M_IDLE;
               q_d    = Q_IDLE;
            end
         end
         default: mode_d = M_IDLE;
      endcase

      if (mode_d != mode_q)  step_cnt_d = '0;
      else if (mode_q == M_HOLD) step_cnt_d = step_cnt_q;
      else if (running)      step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
      else                   step_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= M_IDLE;
         saved_q    <= M_CHASE;
         q_q        <= Q_IDLE;
         btn_evt_q  <= 3'b000;
         step_cnt_q <= '0;
      end else begin
         mode_q     <= mode_d;
         saved_q    <= saved_d;
         q_q        <= q_d;
         btn_evt_q  <= btn_evt_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign q       = q_q;
   assign mode    = mode_q;
   assign btn_evt = btn_evt_q;

endmodule
